fetch_ctrl: RTL and testbench

//   Sequences instruction fetch around the next-PC datapath. Holds the architectural PC,

---
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs the imem request/ack handshake and
// presents fetched instructions to decode. Optional ack timeout: define FETCH_TIMEOUT_EN.
`timescale 1ns/1ps

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        stall,
    input  logic [1:0]  pc_source,
    input  logic [31:0] reg_target,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        fetch_err
);

    if (MAX_WAIT < 1) begin : g_bad_wait
        $error("fetch_ctrl: MAX_WAIT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT - 1);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_q;
    logic [31:0] inst_d;

    logic [31:0] pc4;
    logic [31:0] branch_off;
    logic        unused_bits;

    // Target-address bits below word alignment are deliberately discarded.
    assign unused_bits = &{1'b0, reg_target[1:0]};

    assign pc4        = pc_q + 32'd4;
    assign branch_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

    always_comb begin
        npc = pc4;
        unique case (pc_source)
            2'b00:   npc = pc4;
            2'b01:   npc = pc4 + branch_off;
            2'b10:   npc = {pc4[31:28], inst_q[25:0], 2'b00};
            2'b11:   npc = {reg_target[31:2], 2'b00};
            default: npc = pc4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            FETCH: begin
                // A same-cycle ack beats the timeout.
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            ISSUE: begin
                if (inst_ready && !stall) begin
                    pc_d    = npc;
                    state_d = FETCH;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
`ifdef FETCH_TIMEOUT_EN
            ERR: begin
                state_d = ERR;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == ISSUE);
    assign pc         = pc_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = (state_q == ERR);
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; checks both the default build and the
// FETCH_TIMEOUT_EN build depending on how it is compiled.
`timescale 1ns/1ps

module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        stall;
    logic [1:0]  pc_source;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .stall      (stall),
        .pc_source  (pc_source),
        .reg_target (reg_target),
        .pc         (pc),
        .npc        (npc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " pc"}, pc, 32'h0);
        checkOutput({tag, " imem_addr"}, imem_addr, 32'h0);
        checkOutput({tag, " inst"}, inst, 32'h0);
        checkOutput({tag, " inst_valid"}, {31'd0, inst_valid}, 32'd0);
        checkOutput({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
        checkOutput({tag, " fetch_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    // Reset, then leave the DUT sitting in its first FETCH cycle.
    task automatic resetDut(input string tag);
        rst = 1'b1;
        tick();
        checkReset(tag);
        rst = 1'b0;
        tick();
        checkOutput({tag, " first fetch req"}, {31'd0, imem_req}, 32'd1);
    endtask

    // One fetch/issue round from a FETCH cycle: ack with rdata, accept with src/tgt.
    task automatic applyStimulus(input logic [31:0] rdata, input logic [1:0] src,
                                 input logic [31:0] tgt, input logic [31:0] expNpc,
                                 input string tag);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        pc_source  = src;
        reg_target = tgt;
        inst_ready = 1'b1;
        stall      = 1'b0;
        tick();
        checkOutput({tag, " inst_valid"}, {31'd0, inst_valid}, 32'd1);
        checkOutput({tag, " inst"}, inst, rdata);
        checkOutput({tag, " npc"}, npc, expNpc);
        tick();
        checkOutput({tag, " pc"}, pc, expNpc);
        checkOutput({tag, " imem_addr"}, imem_addr, expNpc);
    endtask

    initial begin
        rst        = 1'b1;
        imem_rdata = 32'h0;
        imem_ack   = 1'b1;
        inst_ready = 1'b1;
        stall      = 1'b0;
        pc_source  = 2'b00;
        reg_target = 32'h0;

        // Sequential fetch with ack and ready always high
        resetDut("t1 reset");
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1 fetch%0d pc", i), pc, 32'(4 * i));
            checkOutput($sformatf("t1 fetch%0d addr", i), imem_addr, 32'(4 * i));
            checkOutput($sformatf("t1 fetch%0d req", i), {31'd0, imem_req}, 32'd1);
            tick();
            checkOutput($sformatf("t1 issue%0d pc", i), pc, 32'(4 * i));
            checkOutput($sformatf("t1 issue%0d valid", i), {31'd0, inst_valid}, 32'd1);
            tick();
        end

        // Branches from pc=0x10
        checkOutput("t2 start pc", pc, 32'h10);
        applyStimulus(32'h1000_FFFF, 2'b01, 32'h0, 32'h0000_0010, "t2 branch back");
        applyStimulus(32'h0000_0003, 2'b01, 32'h0, 32'h0000_0020, "t2 branch fwd");

        // Jump and register jump
        applyStimulus(32'h0, 2'b11, 32'hF000_0000, 32'hF000_0000, "t3 to F0000000");
        applyStimulus(32'h0000_0100, 2'b10, 32'h0, 32'hF000_0400, "t3 jump");
        applyStimulus(32'h0, 2'b11, 32'h0000_1237, 32'h0000_1234, "t3 regjump");

        // Stall holds ISSUE even with ready high
        imem_ack   = 1'b1;
        imem_rdata = 32'hABCD_0000;
        pc_source  = 2'b00;
        inst_ready = 1'b1;
        stall      = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t4 stall%0d valid", i), {31'd0, inst_valid}, 32'd1);
            checkOutput($sformatf("t4 stall%0d pc", i), pc, 32'h0000_1234);
            checkOutput($sformatf("t4 stall%0d inst", i), inst, 32'hABCD_0000);
        end
        stall = 1'b0;
        tick();
        checkOutput("t4 release pc", pc, 32'h0000_1238);
        checkOutput("t4 release req", {31'd0, imem_req}, 32'd1);

        // Ack withheld
        imem_ack   = 1'b0;
        imem_rdata = 32'h5555_AAAA;
`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        checkOutput("t5 wait15 err", {31'd0, fetch_err}, 32'd0);
        checkOutput("t5 wait15 req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1;
        tick();
        checkOutput("t5 late ack valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("t5 late ack err", {31'd0, fetch_err}, 32'd0);
        checkOutput("t5 late ack inst", inst, 32'h5555_AAAA);
        tick();
        checkOutput("t5 after ack pc", pc, 32'h0000_123C);
        imem_ack = 1'b0;
        repeat (15) tick();
        checkOutput("t5 pre timeout err", {31'd0, fetch_err}, 32'd0);
        tick();
        checkOutput("t5 timeout err", {31'd0, fetch_err}, 32'd1);
        checkOutput("t5 timeout req", {31'd0, imem_req}, 32'd0);
        checkOutput("t5 timeout valid", {31'd0, inst_valid}, 32'd0);
        imem_ack = 1'b1;
        repeat (3) tick();
        checkOutput("t5 sticky err", {31'd0, fetch_err}, 32'd1);
        checkOutput("t5 sticky req", {31'd0, imem_req}, 32'd0);
`else
        repeat (40) tick();
        checkOutput("t5 waiting req", {31'd0, imem_req}, 32'd1);
        checkOutput("t5 waiting err", {31'd0, fetch_err}, 32'd0);
        checkOutput("t5 waiting valid", {31'd0, inst_valid}, 32'd0);
        checkOutput("t5 waiting pc", pc, 32'h0000_1238);
        imem_ack = 1'b1;
        tick();
        checkOutput("t5 late ack valid", {31'd0, inst_valid}, 32'd1);
        checkOutput("t5 late ack inst", inst, 32'h5555_AAAA);
`endif

        // Reset mid-FETCH, mid-ISSUE, and PC wrap
        resetDut("t6 reset");
        imem_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkReset("t6 mid-fetch");
        rst = 1'b0;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        inst_ready = 1'b0;
        tick();
        checkOutput("t6 in issue", {31'd0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        rst = 1'b1;
        tick();
        checkReset("t6 mid-issue");
        rst = 1'b0;
        tick();
        applyStimulus(32'h0, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "t6 to top");
        applyStimulus(32'h0, 2'b00, 32'h0, 32'h0000_0000, "t6 wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
